// File: rtl/fp2int_fp32.sv
// fp2int_fp32: IEEE-754 single to sign-magnitude integer, round-half-even.
// Three stages: decode/unbias, align shift, round/saturate.
module fp2int_fp32 #(
   parameter int MAX_BITWIDTH_QUANTIZED_DATA = 16
) (
   input  logic                                   clk,
   input  logic                                   rstn,
   input  logic                                   values_rdy,
   input  logic [31:0]                            fp_in,
   input  logic                                   clr_count,
   output logic                                   result_rdy,
   output logic                                   sign,
   output logic [MAX_BITWIDTH_QUANTIZED_DATA-1:0] quantized_d,
   output logic                                   sat_flag,
   output logic                                   nan_flag,
   output logic [15:0]                            sat_count
);

   localparam int N = MAX_BITWIDTH_QUANTIZED_DATA;
   localparam int WW = 24 + N;
   localparam logic [7:0] L_ESAT = 8'(127 + N);

   typedef enum logic [1:0] {
      C_ZERO,
      C_NUM,
      C_SAT,
      C_NAN
   } cls_t;

   logic [7:0]  w_e;
   logic [22:0] w_m;
   cls_t        w_cls;

   logic        r_s1_v;
   logic        r_s1_s;
   cls_t        r_s1_cls;
   logic [23:0] r_s1_sig;
   logic [4:0]  r_s1_sh;

   logic [WW-1:0] w_wide;

   logic         r_s2_v;
   logic         r_s2_s;
   cls_t         r_s2_cls;
   logic [N-1:0] r_s2_int;
   logic         r_s2_grd;
   logic         r_s2_stk;

   logic         w_inc;
   logic [N:0]   w_sum;
   logic [N-1:0] w_mag;
   logic         w_sgn;
   logic         w_sat;
   logic         w_nan;

   assign w_e = fp_in[30:23];
   assign w_m = fp_in[22:0];

   always_comb begin
      w_cls = C_NUM;
      if (w_e == 8'hFF)
         w_cls = (w_m != 23'd0) ? C_NAN : C_SAT;
      else if (w_e < 8'd126)
         w_cls = C_ZERO;
      else if (w_e >= L_ESAT)
         w_cls = C_SAT;
   end

   // Shift = E+1 = e-126; modulo 32 that is e[4:0]+2, exact for E in [-1, N-1]
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_s1_v   <= 1'b0;
         r_s1_s   <= 1'b0;
         r_s1_cls <= C_ZERO;
         r_s1_sig <= '0;
         r_s1_sh  <= '0;
      end else begin
         r_s1_v <= values_rdy;
         if (values_rdy) begin
            r_s1_s   <= fp_in[31];
            r_s1_cls <= w_cls;
            r_s1_sig <= {1'b1, w_m};
            r_s1_sh  <= w_e[4:0] + 5'd2;
         end
      end
   end

   // Binary point sits between bits 24 and 23 of the shifted significand
   assign w_wide = {{N{1'b0}}, r_s1_sig} << r_s1_sh;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_s2_v   <= 1'b0;
         r_s2_s   <= 1'b0;
         r_s2_cls <= C_ZERO;
         r_s2_int <= '0;
         r_s2_grd <= 1'b0;
         r_s2_stk <= 1'b0;
      end else begin
         r_s2_v <= r_s1_v;
         if (r_s1_v) begin
            r_s2_s   <= r_s1_s;
            r_s2_cls <= r_s1_cls;
            r_s2_int <= w_wide[WW-1:24];
            r_s2_grd <= w_wide[23];
            r_s2_stk <= |w_wide[22:0];
         end
      end
   end

   assign w_inc = r_s2_grd & (r_s2_stk | r_s2_int[0]);
   assign w_sum = {1'b0, r_s2_int} + {{N{1'b0}}, w_inc};

   always_comb begin
      w_mag = '0;
      w_sgn = r_s2_s;
      w_sat = 1'b0;
      w_nan = 1'b0;
      unique case (r_s2_cls)
         C_NUM: begin
            if (w_sum[N]) begin
               w_mag = '1;
               w_sat = 1'b1;
            end else begin
               w_mag = w_sum[N-1:0];
            end
         end
         C_SAT: begin
            w_mag = '1;
            w_sat = 1'b1;
         end
         C_NAN: begin
            w_mag = '1;
            w_sgn = 1'b0;
            w_nan = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         result_rdy  <= 1'b0;
         sign        <= 1'b0;
         quantized_d <= '0;
         sat_flag    <= 1'b0;
         nan_flag    <= 1'b0;
      end else begin
         result_rdy <= r_s2_v;
         if (r_s2_v) begin
            sign        <= w_sgn;
            quantized_d <= w_mag;
            sat_flag    <= w_sat;
            nan_flag    <= w_nan;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         sat_count <= '0;
      else if (clr_count)
         sat_count <= '0;
      else if (result_rdy && (sat_flag || nan_flag) && sat_count != 16'hFFFF)
         sat_count <= sat_count + 16'd1;
   end

endmodule

// File: tb/tb_fp2int_fp32.sv
// tb_fp2int_fp32: random + directed stimulus, scoreboard queue,
// integer-arithmetic reference model.
module tb_fp2int_fp32;

   localparam int N = 16;
   localparam logic [63:0] MAXV = (64'd1 << N) - 64'd1;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         values_rdy = 1'b0;
   logic [31:0]  fp_in = 32'd0;
   logic         clr_count = 1'b0;
   logic         result_rdy;
   logic         sign;
   logic [N-1:0] quantized_d;
   logic         sat_flag;
   logic         nan_flag;
   logic [15:0]  sat_count;

   fp2int_fp32 #(.MAX_BITWIDTH_QUANTIZED_DATA(N)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .values_rdy  (values_rdy),
      .fp_in       (fp_in),
      .clr_count   (clr_count),
      .result_rdy  (result_rdy),
      .sign        (sign),
      .quantized_d (quantized_d),
      .sat_flag    (sat_flag),
      .nan_flag    (nan_flag),
      .sat_count   (sat_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic         s;
      logic [N-1:0] mag;
      logic         sat;
      logic         nan;
      int           cyc;
   } exp_t;

   exp_t        q[$];
   exp_t        last;
   logic [15:0] exp_cnt = 16'd0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  nm, act, req, cyc);
      end
   endtask

   // Value = sig * 2^(E-23); round half to even with plain integer math
   function automatic exp_t model(input logic [31:0] f);
      exp_t r;
      int e;
      int ex;
      int sh;
      logic [63:0] sig;
      logic [63:0] qv;
      logic [63:0] rem;
      logic [63:0] half;
      logic [63:0] val;
      e = int'(f[30:23]);
      r.s = f[31];
      r.mag = '0;
      r.sat = 1'b0;
      r.nan = 1'b0;
      r.cyc = 0;
      if (e == 255) begin
         r.mag = '1;
         if (f[22:0] != 23'd0) begin
            r.s = 1'b0;
            r.nan = 1'b1;
         end else begin
            r.sat = 1'b1;
         end
      end else if (e != 0) begin
         ex = e - 127;
         sig = {40'd0, 1'b1, f[22:0]};
         if (ex > 40) begin
            val = MAXV + 64'd1;
         end else if (ex >= 23) begin
            val = sig << (ex - 23);
         end else begin
            sh = 23 - ex;
            if (sh > 60) begin
               val = 64'd0;
            end else begin
               qv = sig >> sh;
               rem = sig - (qv << sh);
               half = 64'd1 << (sh - 1);
               if (rem > half || (rem == half && qv[0]))
                  qv = qv + 64'd1;
               val = qv;
            end
         end
         if (val > MAXV) begin
            r.mag = '1;
            r.sat = 1'b1;
         end else begin
            r.mag = val[N-1:0];
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] rand_fp();
      logic [7:0]  e;
      logic [22:0] m;
      int k;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)
         e = 8'd0;
      else if (sel == 1)
         e = 8'd255;
      else if (sel < 4)
         e = 8'($urandom_range(0, 255));
      else
         e = 8'($urandom_range(120, 127 + N + 1));
      m = 23'($urandom);
      k = int'($urandom_range(0, 23));
      sel = int'($urandom_range(0, 3));
      if (sel == 0)
         m = 23'd0;
      else if (sel == 1)
         m = m & ~23'((64'd1 << k) - 64'd1);
      else if (sel == 2 && k < 23)
         m = 23'(64'd1 << k);
      return {1'($urandom), e, m};
   endfunction

   task automatic drive(input logic v, input logic [31:0] f,
                        input logic clr);
      exp_t e;
      @(posedge clk);
      #1;
      values_rdy = v;
      fp_in = f;
      clr_count = clr;
      if (v) begin
         e = model(f);
         e.cyc = cyc;
         q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 32'd0, 1'b0);
   endtask

   // Monitor: pops the scoreboard on result_rdy, else checks hold
   initial begin
      exp_t e;
      logic inc;
      last = '{s: 1'b0, mag: '0, sat: 1'b0, nan: 1'b0, cyc: 0};
      forever begin
         @(negedge clk);
         if (!rstn) begin
            chk("reset_outputs", 64'({result_rdy, sign, quantized_d,
                sat_flag, nan_flag, sat_count}), 64'd0);
            exp_cnt = 16'd0;
            last = '{s: 1'b0, mag: '0, sat: 1'b0, nan: 1'b0, cyc: 0};
         end else begin
            chk("sat_count", 64'(sat_count), 64'(exp_cnt));
            inc = 1'b0;
            if (result_rdy) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL spurious_result: got result_rdy=1 expected 0 at cycle %0d",
                           cyc);
               end else begin
                  e = q.pop_front();
                  chk("sign", 64'(sign), 64'(e.s));
                  chk("quantized_d", 64'(quantized_d), 64'(e.mag));
                  chk("sat_flag", 64'(sat_flag), 64'(e.sat));
                  chk("nan_flag", 64'(nan_flag), 64'(e.nan));
                  chk("latency", 64'(cyc - e.cyc), 64'd3);
                  last = e;
                  inc = e.sat | e.nan;
               end
            end else begin
               chk("hold", 64'({sign, quantized_d, sat_flag, nan_flag}),
                   64'({last.s, last.mag, last.sat, last.nan}));
            end
            if (clr_count)
               exp_cnt = 16'd0;
            else if (inc && exp_cnt != 16'hFFFF)
               exp_cnt = exp_cnt + 16'd1;
         end
      end
   end

   initial begin
      int w;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;

      drive(1'b1, 32'h3F800000, 1'b0);
      idle(4);

      drive(1'b1, 32'h3F000000, 1'b0);
      drive(1'b1, 32'h3FC00000, 1'b0);
      drive(1'b1, 32'hC0200000, 1'b0);
      drive(1'b1, 32'h40600000, 1'b0);
      drive(1'b1, 32'h00000001, 1'b0);
      idle(5);

      drive(1'b1, 32'h477FFF80, 1'b0);
      drive(1'b1, 32'h47800000, 1'b0);
      idle(5);
      chk("sat_count_two", 64'(sat_count), 64'd2);

      drive(1'b1, 32'h7F800000, 1'b0);
      drive(1'b1, 32'h7FC00000, 1'b0);
      drive(1'b1, 32'hFF800000, 1'b0);
      drive(1'b1, 32'h3F400000, 1'b0);
      idle(5);

      drive(1'b1, 32'h7F800000, 1'b0);
      idle(2);
      drive(1'b0, 32'd0, 1'b1);
      idle(1);
      chk("clr_priority", 64'(sat_count), 64'd0);

      drive(1'b1, 32'h40400000, 1'b0);
      drive(1'b1, 32'h7F800000, 1'b0);
      drive(1'b1, 32'h41200000, 1'b0);
      @(negedge clk);
      #1;
      rstn = 1'b0;
      values_rdy = 1'b0;
      q.delete();
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      idle(6);
      drive(1'b1, 32'h40A00000, 1'b0);
      idle(5);

      for (int i = 0; i < 2000; i++)
         drive($urandom_range(0, 9) < 7, rand_fp(),
               $urandom_range(0, 19) == 0);
      idle(5);

      for (int i = 0; i < 70000; i++)
         drive(1'b1, 32'h7F800000, 1'b0);
      idle(5);
      chk("sat_count_hold_max", 64'(sat_count), 64'hFFFF);

      w = 0;
      while (q.size() != 0 && w < 20) begin
         @(posedge clk);
         w++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending results expected 0", q.size());
      end
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
